// File: rtl/alu_bist_driver_if.sv
// Operand/result bus between the BIST driver and the registered ALU wrapper.
// master = driver side, slave = ALU wrapper side.
interface alu_bist_driver_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_over;
    logic        alu_zero;
    logic        alu_neg;

    modport master (
        output alu_a, alu_b, alu_op, alu_shamt,
        input  alu_result, alu_cout, alu_over, alu_zero, alu_neg
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_shamt,
        output alu_result, alu_cout, alu_over, alu_zero, alu_neg
    );
endinterface

// File: rtl/alu_bist_driver.sv
// ALU self-test initiator: issues LFSR operands to the ALU wrapper and folds the
// responses, captured LAT cycles later, into a 32-bit MISR signature.
module alu_bist_driver #(
    parameter int unsigned N_VECTORS = 32'd256,
    parameter int unsigned LAT       = 32'd2,
    parameter logic [31:0] SEED_A    = 32'h0000_0001,
    parameter logic [31:0] SEED_B    = 32'hACE1_2468,
    parameter logic [31:0] POLY      = 32'h0040_0007
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    alu_bist_driver_if.master         alu,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               signature,
    output logic [15:0]               vec_count
);

    localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0000_0000) ? 32'h0000_0001 : SEED_A;
    localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0000_0000) ? 32'h0000_0001 : SEED_B;
    localparam logic [15:0] LAST_IDX   = 16'(N_VECTORS - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? POLY : 32'h0000_0000);
    endfunction

    state_e           state_q, state_d;
    logic [31:0]      lfsr_a_q, lfsr_a_d;
    logic [31:0]      lfsr_b_q, lfsr_b_d;
    logic [15:0]      issue_cnt_q, issue_cnt_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             port_vld_q, port_vld_d;
    logic [LAT-1:0]   vpipe_q, vpipe_d;
    logic [31:0]      sig_q, sig_d;
    logic [15:0]      vec_cnt_q, vec_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // port_vld_q marks the vector currently on the ports; vpipe_q follows it so
    // the top bit is set exactly in the cycle its response is at the inputs.
    logic [LAT:0]     vld_all_s;
    logic [31:0]      capture_s;
    logic             tap_s;

    // Next-state, vector generation, capture and MISR update.
    always_comb begin
        vld_all_s   = {vpipe_q, port_vld_q};
        vpipe_d     = vld_all_s[LAT-1:0];
        tap_s       = vpipe_q[LAT-1];
        capture_s   = alu.alu_result ^ {alu.alu_cout, alu.alu_over, alu.alu_zero, alu.alu_neg, 28'h000_0000};

        state_d     = state_q;
        lfsr_a_d    = lfsr_a_q;
        lfsr_b_d    = lfsr_b_q;
        issue_cnt_d = issue_cnt_q;
        alu_a_d     = 32'h0000_0000;
        alu_b_d     = 32'h0000_0000;
        alu_op_d    = 4'h0;
        port_vld_d  = 1'b0;
        sig_d       = sig_q;
        vec_cnt_d   = vec_cnt_q;

        if (tap_s && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
            sig_d     = lfsr_step(sig_q) ^ capture_s;
            vec_cnt_d = vec_cnt_q + 16'd1;
        end else begin
            sig_d     = sig_q;
            vec_cnt_d = vec_cnt_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    lfsr_a_d    = SEED_A_EFF;
                    lfsr_b_d    = SEED_B_EFF;
                    issue_cnt_d = 16'd0;
                    sig_d       = 32'h0000_0000;
                    vec_cnt_d   = 16'd0;
                    state_d     = S_RUN;
                end else begin
                    state_d     = state_q;
                end
            end
            S_RUN: begin
                alu_a_d     = lfsr_a_q;
                alu_b_d     = lfsr_b_q;
                alu_op_d    = issue_cnt_q[3:0];
                port_vld_d  = 1'b1;
                lfsr_a_d    = lfsr_step(lfsr_a_q);
                lfsr_b_d    = lfsr_step(lfsr_b_q);
                issue_cnt_d = issue_cnt_q + 16'd1;
                if (issue_cnt_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                // Leave once only the capturing tap (if any) is still set.
                if (vpipe_d == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_a_q    <= SEED_A_EFF;
            lfsr_b_q    <= SEED_B_EFF;
            issue_cnt_q <= 16'd0;
            alu_a_q     <= 32'h0000_0000;
            alu_b_q     <= 32'h0000_0000;
            alu_op_q    <= 4'h0;
            port_vld_q  <= 1'b0;
            vpipe_q     <= '0;
            sig_q       <= 32'h0000_0000;
            vec_cnt_q   <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            issue_cnt_q <= issue_cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            port_vld_q  <= port_vld_d;
            vpipe_q     <= vpipe_d;
            sig_q       <= sig_d;
            vec_cnt_q   <= vec_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign alu.alu_a     = alu_a_q;
    assign alu.alu_b     = alu_b_q;
    assign alu.alu_op    = alu_op_q;
    assign alu.alu_shamt = 5'b00000;
    assign busy          = busy_q;
    assign done          = done_q;
    assign signature     = sig_q;
    assign vec_count     = vec_cnt_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Bench for alu_bist_driver: a behavioural two-stage ALU model answers the driver,
// and a reference model recomputes vectors and signatures from the seeds.
module tb_alu_bist_driver;

    localparam int          N      = 4;
    localparam int          NK     = 2;
    localparam int          LAT    = 2;
    localparam logic [31:0] SEED_A = 32'h0000_0001;
    localparam logic [31:0] SEED_B = 32'hACE1_2468;
    localparam logic [31:0] POLY   = 32'h0040_0007;

    logic        clk = 1'b0;
    logic        rst, start, start_k;
    logic        busy, done, busy_k, done_k;
    logic [31:0] signature, signature_k;
    logic [15:0] vec_count, vec_count_k;

    int          n_pass = 0;
    int          n_total = 0;
    int          mode = 0;
    logic [31:0] k_res = 32'h0;
    logic [3:0]  k_flags = 4'h0;
    logic [31:0] sig1;

    always #5 clk = ~clk;

    alu_bist_driver_if bus();
    alu_bist_driver_if bus_k();

    alu_bist_driver #(.N_VECTORS(N), .LAT(LAT), .SEED_A(SEED_A), .SEED_B(SEED_B), .POLY(POLY)) dut (
        .clk(clk), .rst(rst), .start(start), .alu(bus),
        .busy(busy), .done(done), .signature(signature), .vec_count(vec_count)
    );

    alu_bist_driver #(.N_VECTORS(NK), .LAT(LAT), .SEED_A(SEED_A), .SEED_B(SEED_B), .POLY(POLY)) dut_k (
        .clk(clk), .rst(rst), .start(start_k), .alu(bus_k),
        .busy(busy_k), .done(done_k), .signature(signature_k), .vec_count(vec_count_k)
    );

    // Behavioural ALU: mode 0 computes, mode 1 answers a fixed result/flags.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [32:0] sum;
        logic [31:0] res;
        if (mode == 1) return {k_res, k_flags};
        sum = {1'b0, a} + {1'b0, b};
        res = (op[0] ? (a - b) : sum[31:0]) ^ {28'h0, op};
        return {res, sum[32], (a[31] == b[31]) && (res[31] != a[31]), res == 32'h0, res[31]};
    endfunction

    logic [31:0] p_a, p_b;
    logic [3:0]  p_op;
    logic [35:0] r_out = 36'h0;
    always @(posedge clk) begin
        p_a   <= bus.alu_a;
        p_b   <= bus.alu_b;
        p_op  <= bus.alu_op;
        r_out <= alu_fn(p_a, p_b, p_op);
    end
    assign bus.alu_result = r_out[35:4];
    assign {bus.alu_cout, bus.alu_over, bus.alu_zero, bus.alu_neg} = r_out[3:0];

    assign bus_k.alu_result = 32'h8000_0000;
    assign {bus_k.alu_cout, bus_k.alu_over, bus_k.alu_zero, bus_k.alu_neg} = 4'h0;

    function automatic logic [31:0] step(input logic [31:0] x);
        return (x << 1) ^ (x[31] ? POLY : 32'h0);
    endfunction

    // Reference: k-th operand from a seed and the signature of an n-vector run.
    function automatic logic [31:0] nth(input logic [31:0] seed, input int k);
        logic [31:0] x = seed;
        for (int i = 0; i < k; i++) x = step(x);
        return x;
    endfunction

    function automatic logic [31:0] model_sig(input int n);
        logic [31:0] s = 32'h0;
        logic [35:0] r;
        for (int k = 0; k < n; k++) begin
            r = alu_fn(nth(SEED_A, k), nth(SEED_B, k), 4'(k));
            s = step(s) ^ (r[35:4] ^ {r[3:0], 28'h0});
        end
        return s;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_k = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_shamt} !== 73'h0) $display("FAIL reset_ports got %h exp 0", {bus.alu_a, bus.alu_b, bus.alu_op}); else n_pass++;
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b exp 00", {busy, done}); else n_pass++;
        n_total++;
        if ({signature, vec_count} !== 48'h0) $display("FAIL reset_sig_cnt got %h/%0d exp 0/0", signature, vec_count); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        mode = 0;
        pulse_start();
        n_total++;
        if ({busy, done} !== 2'b10) $display("FAIL busy_rise got %b exp 10", {busy, done}); else n_pass++;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            n_total++;
            if (bus.alu_a !== nth(SEED_A, k) || bus.alu_b !== nth(SEED_B, k) || bus.alu_op !== 4'(k) || bus.alu_shamt !== 5'h0)
                $display("FAIL vector_%0d got a=%h b=%h op=%0d exp a=%h b=%h op=%0d", k, bus.alu_a, bus.alu_b, bus.alu_op, nth(SEED_A, k), nth(SEED_B, k), k);
            else n_pass++;
        end
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clk);
            n_total++;
            if (done !== (i == LAT + 1)) $display("FAIL done_timing cycle %0d got %b exp %b", i, done, i == LAT + 1); else n_pass++;
            if (i == 1) begin
                n_total++;
                if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 68'h0 || busy !== 1'b1) $display("FAIL drain_ports got a=%h busy=%b exp 0/1", bus.alu_a, busy); else n_pass++;
            end
        end
        n_total++;
        if (vec_count !== 16'(N) || busy !== 1'b0) $display("FAIL run_count got %0d busy=%b exp %0d busy=0", vec_count, busy, N); else n_pass++;
        n_total++;
        if (signature !== model_sig(N)) $display("FAIL run_sig got %h exp %h", signature, model_sig(N)); else n_pass++;
        sig1 = signature;
    endtask

    task automatic test_restart();
        int cyc;
        pulse_start();
        @(negedge clk);
        n_total++;
        if (bus.alu_a !== SEED_A || bus.alu_b !== SEED_B || done !== 1'b0) $display("FAIL restart_first got a=%h b=%h done=%b exp %h %h 0", bus.alu_a, bus.alu_b, done, SEED_A, SEED_B); else n_pass++;
        wait_done(cyc);
        n_total++;
        if (done !== 1'b1 || signature !== sig1 || vec_count !== 16'(N)) $display("FAIL restart_sig got %h/%0d exp %h/%0d", signature, vec_count, sig1, N); else n_pass++;
    endtask

    task automatic test_known_answer();
        int cyc;
        @(negedge clk) start_k = 1'b1;
        @(negedge clk) start_k = 1'b0;
        cyc = 0;
        while (!done_k && cyc < 100) begin @(negedge clk); cyc++; end
        n_total++;
        if (signature_k !== 32'h8040_0007 || vec_count_k !== 16'(NK)) $display("FAIL kat_msb got %h/%0d exp 80400007/%0d", signature_k, vec_count_k, NK); else n_pass++;
        mode = 1; k_res = 32'h0; k_flags = 4'b0010;
        pulse_start();
        wait_done(cyc);
        n_total++;
        if (signature !== 32'hE040_0007) $display("FAIL kat_zero got %h exp e0400007", signature); else n_pass++;
        for (int r = 0; r < 3; r++) begin
            k_res = $urandom; k_flags = 4'($urandom_range(0, 15));
            pulse_start();
            wait_done(cyc);
            n_total++;
            if (signature !== model_sig(N) || vec_count !== 16'(N)) $display("FAIL kat_rand_%0d got %h exp %h", r, signature, model_sig(N)); else n_pass++;
        end
        mode = 0;
    endtask

    task automatic test_start_ignored();
        int cyc;
        int seq_err;
        pulse_start();
        cyc = 0; seq_err = 0;
        while (!done && cyc < 200) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (cyc >= 1 && cyc <= N && bus.alu_a !== nth(SEED_A, cyc - 1)) seq_err++;
        end
        start = 1'b0;
        n_total++;
        if (cyc != N + LAT + 1 || seq_err != 0) $display("FAIL start_ignored_seq got cycles=%0d errs=%0d exp %0d/0", cyc, seq_err, N + LAT + 1); else n_pass++;
        n_total++;
        if (signature !== model_sig(N) || vec_count !== 16'(N)) $display("FAIL start_ignored_sig got %h/%0d exp %h/%0d", signature, vec_count, model_sig(N), N); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int cyc;
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op, busy, done, signature, vec_count} !== 118'h0) $display("FAIL midrun_reset got a=%h busy=%b sig=%h cnt=%0d exp 0", bus.alu_a, busy, signature, vec_count); else n_pass++;
        repeat (6) @(negedge clk);
        n_total++;
        if ({busy, done, signature, vec_count} !== 50'h0) $display("FAIL midrun_inflight got busy=%b done=%b sig=%h cnt=%0d exp 0", busy, done, signature, vec_count); else n_pass++;
        pulse_start();
        wait_done(cyc);
        n_total++;
        if (done !== 1'b1 || signature !== model_sig(N) || vec_count !== 16'(N)) $display("FAIL midrun_rerun got %h/%0d exp %h/%0d", signature, vec_count, model_sig(N), N); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_k = 1'b0;
        test_reset();
        test_sequence();
        test_restart();
        test_known_answer();
        test_start_ignored();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
